// File: rtl/serial_mp_add_sub_pkg.sv
// Shared types and helpers for the word-serial multi-precision adder/subtractor.
package serial_mp_add_sub_pkg;

  localparam int unsigned RADIX_DEF     = 32;
  localparam int unsigned NUM_WORDS_DEF = 14;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word-address width for n words; never less than one bit so N=1 still has an address port.
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_mp_add_sub_unit_adder.sv
// One-word adder with carry in/out; purely combinational.
module serial_mp_add_sub_unit_adder #(
  parameter int unsigned RADIX = 32
) (
  input  logic [RADIX-1:0] din_a,
  input  logic [RADIX-1:0] din_b,
  input  logic             carry_in,
  output logic [RADIX-1:0] sum_c,
  output logic             carry_out_c
);

  logic [RADIX:0] full_c;

  assign full_c      = {1'b0, din_a} + {1'b0, din_b} + (RADIX+1)'(carry_in);
  assign sum_c       = full_c[RADIX-1:0];
  assign carry_out_c = full_c[RADIX];

endmodule

// File: rtl/serial_mp_add_sub.sv
// Word-serial a+b / a-b over NUM_WORDS words streamed LSW first from operand RAMs to a result RAM.
module serial_mp_add_sub
  import serial_mp_add_sub_pkg::*;
#(
  parameter int unsigned RADIX     = RADIX_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned ADDR_W    = addr_width(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic              carry_borrow,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RADIX-1:0]  a_word,
  input  logic [RADIX-1:0]  b_word,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RADIX-1:0]  wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_e            state, state_d;
  op_e               op_q, op_d;
  logic              carry_q, carry_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;

  logic              busy_d, done_d, carry_borrow_d;
  logic              rd_en_d, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  logic [RADIX-1:0]  wr_data_d;

  logic [RADIX-1:0]  b_eff_c;
  logic [RADIX-1:0]  sum_c;
  logic              carry_out_c;

  // Subtraction is a + ~b with the carry chain seeded to 1 at start.
  assign b_eff_c = (op_q == OP_SUB) ? ~b_word : b_word;

  serial_mp_add_sub_unit_adder #(
    .RADIX (RADIX)
  ) u_unit_adder (
    .din_a       (a_word),
    .din_b       (b_eff_c),
    .carry_in    (carry_q),
    .sum_c       (sum_c),
    .carry_out_c (carry_out_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state;
    op_d           = op_q;
    carry_d        = carry_q;
    rd_valid_d     = 1'b0;
    wr_cnt_d       = wr_cnt_q;
    busy_d         = busy;
    done_d         = 1'b0;
    carry_borrow_d = carry_borrow;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr;
    wr_data_d      = wr_data;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          op_d      = op_e'(sub);
          carry_d   = sub;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          wr_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        rd_valid_d = rd_en;
        if (rd_en && (rd_addr != LAST_ADDR)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr + ADDR_W'(1);
        end
        if (rd_valid_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_cnt_q;
          wr_data_d = sum_c;
          carry_d   = carry_out_c;
          wr_cnt_d  = wr_cnt_q + ADDR_W'(1);
        end
        // Finish once the last result word is on the write port.
        if (wr_en && (wr_addr == LAST_ADDR)) begin
          state_d        = ST_DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          carry_borrow_d = (op_q == OP_SUB) ? ~carry_q : carry_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_ADD;
      carry_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_cnt_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      carry_borrow <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      state        <= state_d;
      op_q         <= op_d;
      carry_q      <= carry_d;
      rd_valid_q   <= rd_valid_d;
      wr_cnt_q     <= wr_cnt_d;
      busy         <= busy_d;
      done         <= done_d;
      carry_borrow <= carry_borrow_d;
      rd_en        <= rd_en_d;
      rd_addr      <= rd_addr_d;
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
    end
  end

endmodule
